// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths and index types for the integer register file
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int REG_IDX_W = 5;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: write-back, issue and ID read-port signals of the register file
interface wb_regfile_if;
  import riscv_pkg::*;
  logic wb_valid;
  logic wb_reg_write;
  reg_idx_t wb_rd;
  xword_t write_back_data;
  reg_idx_t rs1_addr;
  reg_idx_t rs2_addr;
  xword_t rs1_data;
  xword_t rs2_data;
  logic issue_en;
  reg_idx_t issue_rd;
  logic rs1_busy;
  logic rs2_busy;
  logic [63:0] retire_count;
  modport master (
    output wb_valid, wb_reg_write, wb_rd, write_back_data, rs1_addr, rs2_addr, issue_en, issue_rd,
    input rs1_data, rs2_data, rs1_busy, rs2_busy, retire_count
  );
  modport slave (
    input wb_valid, wb_reg_write, wb_rd, write_back_data, rs1_addr, rs2_addr, issue_en, issue_rd,
    output rs1_data, rs2_data, rs1_busy, rs2_busy, retire_count
  );
endinterface

// File: rtl/scoreboard.sv
// scoreboard: per-register busy bits, set at issue, cleared at write-back
module scoreboard
  import riscv_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     we_i,
  input  reg_idx_t wb_rd_i,
  input  logic     issue_en_i,
  input  reg_idx_t issue_rd_i,
  input  reg_idx_t rs1_addr_i,
  input  reg_idx_t rs2_addr_i,
  output logic     rs1_busy_o,
  output logic     rs2_busy_o
);
  logic [NREG-1:0] busy_q, busy_d, set_mask, clr_mask;
  // set is applied after clear so a younger producer wins; x0 is never busy
  always_comb begin
    clr_mask = we_i ? NREG'(1) << wb_rd_i : '0;
    set_mask = (issue_en_i && issue_rd_i != REG_ZERO) ? NREG'(1) << issue_rd_i : '0;
    busy_d = ((busy_q & ~clr_mask) | set_mask) & ~NREG'(1);
  end
  // busy vector, dropped entirely on reset
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  // a result arriving this cycle is bypassed, so it masks its own busy bit
  always_comb begin
    rs1_busy_o = busy_q[rs1_addr_i] & ~(we_i && wb_rd_i == rs1_addr_i);
    rs2_busy_o = busy_q[rs2_addr_i] & ~(we_i && wb_rd_i == rs2_addr_i);
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: architectural register file with write-through bypass, busy scoreboard and retire counter
module wb_regfile
  import riscv_pkg::*;
(
  input logic clk,
  input logic rst,
  wb_regfile_if.slave bus
);
  xword_t regs_q [NREG];
  logic [63:0] retire_q, retire_d;
  logic we;
  assign we = bus.wb_valid && bus.wb_reg_write && bus.wb_rd != REG_ZERO;
  // commit the write-back value; reset clears the whole array
  always_ff @(posedge clk) begin
    if (rst) regs_q <= '{default: '0};
    else if (we) regs_q[bus.wb_rd] <= bus.write_back_data;
  end
  // every retiring instruction counts, whether or not it writes rd
  always_comb retire_d = retire_q + {63'd0, bus.wb_valid};
  // retire counter, wraps naturally at 2^64
  always_ff @(posedge clk) retire_q <= rst ? '0 : retire_d;
  // read ports: x0 reads zero, a same-cycle write is bypassed, else the array
  always_comb begin
    bus.rs1_data = bus.rs1_addr == REG_ZERO ? '0 :
                   (we && bus.wb_rd == bus.rs1_addr) ? bus.write_back_data : regs_q[bus.rs1_addr];
    bus.rs2_data = bus.rs2_addr == REG_ZERO ? '0 :
                   (we && bus.wb_rd == bus.rs2_addr) ? bus.write_back_data : regs_q[bus.rs2_addr];
    bus.retire_count = retire_q;
  end
  scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .we_i      (we),
    .wb_rd_i   (bus.wb_rd),
    .issue_en_i(bus.issue_en),
    .issue_rd_i(bus.issue_rd),
    .rs1_addr_i(bus.rs1_addr),
    .rs2_addr_i(bus.rs2_addr),
    .rs1_busy_o(bus.rs1_busy),
    .rs2_busy_o(bus.rs2_busy)
  );
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors with hand-computed expectations for wb_regfile
module tb_wb_regfile;
  logic clk = 0;
  logic rst;
  int n_chk = 0;
  int n_pass = 0;
  wb_regfile_if bus ();
  wb_regfile dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic idle();
    bus.wb_valid = 0;
    bus.wb_reg_write = 0;
    bus.wb_rd = 0;
    bus.write_back_data = 0;
    bus.issue_en = 0;
    bus.issue_rd = 0;
  endtask
  task automatic wb(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] d);
    bus.wb_valid = v;
    bus.wb_reg_write = w;
    bus.wb_rd = rd;
    bus.write_back_data = d;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    bus.rs1_addr = 0;
    bus.rs2_addr = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    bus.rs1_addr = 1;
    bus.rs2_addr = 31;
    #1;
    check("rst_x1", bus.rs1_data, 0);
    check("rst_x31", bus.rs2_data, 0);
    check("rst_busy1", bus.rs1_busy, 0);
    check("rst_busy2", bus.rs2_busy, 0);
    check("rst_cnt", bus.retire_count, 0);
    wb(1, 1, 5, 32'hDEAD_BEEF);
    bus.rs1_addr = 5;
    #1;
    check("x5_bypass", bus.rs1_data, 32'hDEAD_BEEF);
    step();
    #1;
    check("x5_array", bus.rs1_data, 32'hDEAD_BEEF);
    check("cnt_1", bus.retire_count, 1);
    wb(1, 1, 0, 32'hFFFF_FFFF);
    bus.rs1_addr = 0;
    bus.rs2_addr = 0;
    #1;
    check("x0_p1_same", bus.rs1_data, 0);
    check("x0_p2_same", bus.rs2_data, 0);
    step();
    #1;
    check("x0_p1_next", bus.rs1_data, 0);
    check("cnt_2", bus.retire_count, 2);
    bus.issue_en = 1;
    bus.issue_rd = 7;
    bus.rs2_addr = 7;
    #1;
    check("busy7_same", bus.rs2_busy, 0);
    step();
    #1;
    check("busy7_set", bus.rs2_busy, 1);
    wb(1, 1, 7, 32'h1234);
    #1;
    check("busy7_masked", bus.rs2_busy, 0);
    check("x7_bypass", bus.rs2_data, 32'h1234);
    step();
    #1;
    check("busy7_clr", bus.rs2_busy, 0);
    check("x7_array", bus.rs2_data, 32'h1234);
    check("cnt_3", bus.retire_count, 3);
    bus.issue_en = 1;
    bus.issue_rd = 9;
    wb(1, 1, 9, 32'h99);
    bus.rs1_addr = 9;
    step();
    #1;
    check("busy9_set_wins", bus.rs1_busy, 1);
    check("x9_array", bus.rs1_data, 32'h99);
    check("cnt_4", bus.retire_count, 4);
    bus.issue_en = 1;
    bus.issue_rd = 0;
    bus.rs2_addr = 0;
    step();
    #1;
    check("busy0_never", bus.rs2_busy, 0);
    wb(0, 1, 5, 32'h55);
    bus.rs2_addr = 5;
    #1;
    check("novalid_nobyp", bus.rs2_data, 32'hDEAD_BEEF);
    step();
    #1;
    check("novalid_keep", bus.rs2_data, 32'hDEAD_BEEF);
    check("novalid_cnt", bus.retire_count, 4);
    rst = 1;
    wb(1, 1, 6, 32'h66);
    bus.issue_en = 1;
    bus.issue_rd = 6;
    step();
    rst = 0;
    bus.rs1_addr = 5;
    bus.rs2_addr = 9;
    #1;
    check("rst_x5", bus.rs1_data, 0);
    check("rst_busy9", bus.rs2_busy, 0);
    check("rst_cnt2", bus.retire_count, 0);
    bus.rs1_addr = 6;
    bus.rs2_addr = 6;
    #1;
    check("rst_x6", bus.rs1_data, 0);
    check("rst_busy6", bus.rs2_busy, 0);
    wb(1, 0, 5, 32'h77);
    bus.rs1_addr = 5;
    #1;
    check("nowrite_nobyp", bus.rs1_data, 0);
    step();
    #1;
    check("nowrite_cnt", bus.retire_count, 1);
    check("nowrite_x5", bus.rs1_data, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
